serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/full_subtractor.sv | 24 ++
 rtl/serial_subtractor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial subtractor slice:
//   - FSM state encodings (ST_IDLE, ST_RUN, ST_DONE), 2 bits wide
//   - legal range of the WIDTH parameter
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  // FSM state encodings, kept as plain 2-bit constants for legacy users.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Legal operand width range.
  localparam int WIDTH_MIN = 32'd1;
  localparam int WIDTH_MAX = 32'd32;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Purely combinational one-bit full subtractor: computes a - b - b_in.
// Ports:
//   a     in  minuend bit
//   b     in  subtrahend bit
//   b_in  in  incoming borrow
//   diff  out difference bit
//   b_out out outgoing borrow
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic diff,
  output logic b_out
);

  // Difference bit is the odd-parity of the three inputs.
  assign diff  = a ^ b ^ b_in;
  // Borrow when b exceeds a, or when a == b and a borrow is already pending.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial, LSB-first subtractor. Operands are accepted on a valid/ready
// handshake, one bit is processed per clock through a single full_subtractor
// cell with a registered borrow, and the result is presented on a valid/ready
// output handshake. out_valid rises exactly WIDTH clocks after the accept edge.
//
// Parameters:
//   WIDTH      operand/result width, 1..32 (default 8)
//
// Ports:
//   clk        in  rising-edge clock
//   rst_n      in  asynchronous active-low reset
//   in_valid   in  operands a/b valid
//   in_ready   out block can accept operands (state IDLE)
//   a          in  minuend, unsigned
//   b          in  subtrahend, unsigned
//   out_valid  out diff/b_out valid (state DONE)
//   out_ready  in  consumer accepts result
//   diff       out a - b modulo 2^WIDTH
//   b_out      out final borrow, 1 iff a < b
//   ovf        out signed overflow flag
//
// Build option:
//   SERIAL_SUBTRACTOR_OVF_EN  when defined, ovf reports two's-complement
//                             overflow of a - b; otherwise ovf is tied low and
//                             no MSB capture registers are built.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Elaboration-time guard on the operand width.
  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic             bor_r;
  logic [CNT_W-1:0] cnt_r;
  logic             b_out_r;

  logic             d_s;
  logic             bor_next_s;
  logic             last_s;
  logic [WIDTH-1:0] diff_shift_s;

  // Single bit cell working on the LSBs of the operand shift registers.
  full_subtractor u_bit_cell (
    .a     (a_sh_r[0]),
    .b     (b_sh_r[0]),
    .b_in  (bor_r),
    .diff  (d_s),
    .b_out (bor_next_s)
  );

  assign last_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Next diff register value: shift right and insert the new bit at the MSB.
  // Built this way so WIDTH=1 needs no empty slice.
  always_comb begin
    diff_shift_s             = diff_r >> 1'b1;
    diff_shift_s[WIDTH-1]    = d_s;
  end

  // Main FSM and datapath: capture, bit-serial run, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      diff_r  <= {WIDTH{1'b0}};
      bor_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      b_out_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // in_ready is implied by being in IDLE.
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            bor_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r <= a_sh_r >> 1'b1;
          b_sh_r <= b_sh_r >> 1'b1;
          diff_r <= diff_shift_s;
          bor_r  <= bor_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_s) begin
            b_out_r <= bor_next_s;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          // Result registers are untouched here, so they stay stable.
          if (out_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_r;
  logic b_msb_r;
  logic ovf_r;

  // Signed overflow: operands of differing sign and result sign differs from a.
  // d_s on the last RUN cycle is the final diff MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && in_valid) begin
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
      end else if ((state_r == ST_RUN) && last_s) begin
        ovf_r <= (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s);
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

  // Handshake flags decode straight from the state register, so neither
  // in_valid nor out_ready reaches in_ready combinationally.
  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign diff      = diff_r;
  assign b_out     = b_out_r;

endmodule : serial_subtractor
